// File: rtl/snake_body_pkg.sv
// Shared snake game constants, direction encoding and tile stepping helpers.
// Used by both the body store and the segment walker.
package snake_body_pkg;

   localparam int GAME_WIDTH  = 18;
   localparam int GAME_HEIGHT = 13;
   localparam int IDX_W       = 5;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   function automatic dir_t opposite(input dir_t d);
      return {d[1], ~d[0]};
   endfunction

   function automatic logic [4:0] step_x(input logic [4:0] x, input dir_t d);
      logic [4:0] r;
      r = x;
      case (d)
         DIR_LEFT:  r = x - 5'd1;
         DIR_RIGHT: r = x + 5'd1;
         default:   r = x;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] step_y(input logic [3:0] y, input dir_t d);
      logic [3:0] r;
      r = y;
      case (d)
         DIR_UP:   r = y - 4'd1;
         DIR_DOWN: r = y + 4'd1;
         default:  r = y;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snake_walker.sv
// Segment streamer: walks from the head tail-ward, one segment per cycle,
// accumulating position from the per-segment direction supplied by the body.
module snake_walker
   import snake_body_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       head_x,
   input  logic [3:0]       head_y,
   input  logic [5:0]       length,
   input  dir_t             seg_dir,
   output logic             active,
   output logic             last,
   output logic [IDX_W-1:0] idx,
   output logic [4:0]       seg_x,
   output logic [3:0]       seg_y
);

   logic             active_q, active_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [4:0]       seg_x_q, seg_x_d;
   logic [3:0]       seg_y_q, seg_y_d;
   logic             at_tail;

   assign at_tail = ({1'b0, idx_q} == length - 6'd1);

   always_comb begin
      active_d = active_q;
      idx_d    = idx_q;
      seg_x_d  = seg_x_q;
      seg_y_d  = seg_y_q;
      if (start) begin
         active_d = 1'b1;
         idx_d    = '0;
         seg_x_d  = head_x;
         seg_y_d  = head_y;
      end else if (active_q) begin
         if (at_tail) begin
            active_d = 1'b0;
         end else begin
            idx_d   = idx_q + 1'b1;
            seg_x_d = step_x(seg_x_q, seg_dir);
            seg_y_d = step_y(seg_y_q, seg_dir);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active_q <= 1'b0;
         idx_q    <= '0;
         seg_x_q  <= '0;
         seg_y_q  <= '0;
      end else begin
         active_q <= active_d;
         idx_q    <= idx_d;
         seg_x_q  <= seg_x_d;
         seg_y_q  <= seg_y_d;
      end
   end

   assign active = active_q;
   assign last   = active_q & at_tail;
   assign idx    = idx_q;
   assign seg_x  = seg_x_q;
   assign seg_y  = seg_y_q;

endmodule

// File: rtl/snake_body.sv
// Snake body: head tile plus direction chain, step/grow handling,
// wall and self-collision detection, and head-to-tail segment streaming.
module snake_body
   import snake_body_pkg::*;
#(
   parameter int MAX_LEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_rst,
   input  logic       step,
   input  logic [1:0] step_dir,
   input  logic       grow,
   input  logic       stream_start,
   output logic [4:0] head_x,
   output logic [3:0] head_y,
   output logic [4:0] snake_x,
   output logic [3:0] snake_y,
   output logic [1:0] snake_dir,
   output logic       snake_first,
   output logic       snake_last,
   output logic       snake_valid,
   output logic [5:0] length,
   output logic       failure,
   output logic       success
);

   localparam int NDIR = MAX_LEN - 1;

   logic             clr;
   logic [4:0]       head_x_q, head_x_d;
   logic [3:0]       head_y_q, head_y_d;
   logic [5:0]       length_q, length_d;
   dir_t             dirs_q [NDIR];
   dir_t             dirs_d [NDIR];
   logic             failure_q, failure_d;
   logic             success_q, success_d;
   logic             pend_q, pend_d;
   dir_t             pend_dir_q, pend_dir_d;
   logic             pend_grow_q, pend_grow_d;

   logic             walk_active, walk_last;
   logic [IDX_W-1:0] walk_idx;
   logic [4:0]       walk_x;
   logic [3:0]       walk_y;
   dir_t             seg_dir;

   logic             busy, cmd_vld, cmd_grow;
   dir_t             cmd_dir, eff_dir;
   logic [4:0]       nx;
   logic [3:0]       ny;

   assign clr = rst | game_rst;

   snake_walker u_walker (
      .clk     (clk),
      .rst     (clr),
      .start   (stream_start),
      .head_x  (head_x_q),
      .head_y  (head_y_q),
      .length  (length_q),
      .seg_dir (seg_dir),
      .active  (walk_active),
      .last    (walk_last),
      .idx     (walk_idx),
      .seg_x   (walk_x),
      .seg_y   (walk_y)
   );

   always_comb begin
      seg_dir = DIR_UP;
      for (int i = 0; i < NDIR; i++)
         if (walk_idx == IDX_W'(i)) seg_dir = dirs_q[i];
   end

   // A newer step replaces whatever is pending.
   assign busy     = walk_active | stream_start;
   assign cmd_vld  = step | pend_q;
   assign cmd_dir  = step ? step_dir : pend_dir_q;
   assign cmd_grow = step ? grow : pend_grow_q;
   assign eff_dir  = (cmd_dir == dirs_q[0]) ? opposite(dirs_q[0]) : cmd_dir;
   assign nx       = step_x(head_x_q, eff_dir);
   assign ny       = step_y(head_y_q, eff_dir);

   always_comb begin
      head_x_d    = head_x_q;
      head_y_d    = head_y_q;
      length_d    = length_q;
      dirs_d      = dirs_q;
      failure_d   = failure_q;
      success_d   = success_q;
      pend_d      = pend_q;
      pend_dir_d  = pend_dir_q;
      pend_grow_d = pend_grow_q;
      if (busy) begin
         if (step) begin
            pend_d      = 1'b1;
            pend_dir_d  = step_dir;
            pend_grow_d = grow;
         end
      end else begin
         pend_d = 1'b0;
         if (cmd_vld && !failure_q && !success_q) begin
            head_x_d = nx;
            head_y_d = ny;
            for (int i = NDIR - 1; i > 0; i--)
               dirs_d[i] = dirs_q[i-1];
            dirs_d[0] = opposite(eff_dir);
            if (cmd_grow && length_q != 6'(MAX_LEN))
               length_d = length_q + 6'd1;
            if (cmd_grow && length_q == 6'(MAX_LEN - 1))
               success_d = 1'b1;
            if (nx == 5'd0 || nx == 5'(GAME_WIDTH + 1) ||
                ny == 4'd0 || ny == 4'(GAME_HEIGHT + 1))
               failure_d = 1'b1;
         end
      end
      if (walk_active && walk_idx != '0 &&
          walk_x == head_x_q && walk_y == head_y_q)
         failure_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         head_x_q    <= 5'd4;
         head_y_q    <= 4'd7;
         length_q    <= 6'd3;
         for (int i = 0; i < NDIR; i++)
            dirs_q[i] <= DIR_LEFT;
         failure_q   <= 1'b0;
         success_q   <= 1'b0;
         pend_q      <= 1'b0;
         pend_dir_q  <= DIR_UP;
         pend_grow_q <= 1'b0;
      end else begin
         head_x_q    <= head_x_d;
         head_y_q    <= head_y_d;
         length_q    <= length_d;
         dirs_q      <= dirs_d;
         failure_q   <= failure_d;
         success_q   <= success_d;
         pend_q      <= pend_d;
         pend_dir_q  <= pend_dir_d;
         pend_grow_q <= pend_grow_d;
      end
   end

   assign head_x      = head_x_q;
   assign head_y      = head_y_q;
   assign length      = length_q;
   assign failure     = failure_q;
   assign success     = success_q;
   assign snake_valid = walk_active;
   assign snake_x     = walk_active ? walk_x : 5'd0;
   assign snake_y     = walk_active ? walk_y : 4'd0;
   assign snake_dir   = walk_active ? seg_dir : DIR_UP;
   assign snake_first = walk_active & (walk_idx == '0);
   assign snake_last  = walk_last;

endmodule

// File: tb/tb_snake_body.sv
// Scoreboard bench for snake_body: directed steps and streams, expected
// segments queued by stimulus and popped by a negedge monitor.
module tb_snake_body;

   localparam logic [1:0] U = 2'd0;
   localparam logic [1:0] D = 2'd1;
   localparam logic [1:0] L = 2'd2;
   localparam logic [1:0] R = 2'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       game_rst = 1'b0;
   logic       step = 1'b0;
   logic [1:0] step_dir = 2'd0;
   logic       grow = 1'b0;
   logic       stream_start = 1'b0;
   logic [4:0] head_x;
   logic [3:0] head_y;
   logic [4:0] snake_x;
   logic [3:0] snake_y;
   logic [1:0] snake_dir;
   logic       snake_first;
   logic       snake_last;
   logic       snake_valid;
   logic [5:0] length;
   logic       failure;
   logic       success;

   typedef struct {
      logic [4:0] x;
      logic [3:0] y;
      logic [1:0] d;
      logic       f;
      logic       l;
      logic       cd;
   } seg_t;

   seg_t exp_q[$];
   seg_t e;
   int   n_vec = 0;
   int   n_err = 0;
   logic mon_en = 1'b0;

   snake_body #(.MAX_LEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .game_rst     (game_rst),
      .step         (step),
      .step_dir     (step_dir),
      .grow         (grow),
      .stream_start (stream_start),
      .head_x       (head_x),
      .head_y       (head_y),
      .snake_x      (snake_x),
      .snake_y      (snake_y),
      .snake_dir    (snake_dir),
      .snake_first  (snake_first),
      .snake_last   (snake_last),
      .snake_valid  (snake_valid),
      .length       (length),
      .failure      (failure),
      .success      (success)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en) begin
         if (snake_valid === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL seg_extra: got (%0d,%0d) with no segment expected",
                        snake_x, snake_y);
            end else begin
               e = exp_q.pop_front();
               if (snake_x !== e.x || snake_y !== e.y ||
                   (e.cd && snake_dir !== e.d) ||
                   snake_first !== e.f || snake_last !== e.l) begin
                  n_err++;
                  $display("FAIL seg: got (%0d,%0d) d%0d f%0b l%0b, want (%0d,%0d) d%0d f%0b l%0b",
                           snake_x, snake_y, snake_dir, snake_first, snake_last,
                           e.x, e.y, e.d, e.f, e.l);
               end
            end
         end else begin
            n_vec++;
            if (snake_valid !== 1'b0 || snake_x !== 5'd0 || snake_y !== 4'd0 ||
                snake_dir !== 2'd0 || snake_first !== 1'b0 || snake_last !== 1'b0) begin
               n_err++;
               $display("FAIL idle_zero: got v%b x%0d y%0d d%0d f%b l%b, want all 0",
                        snake_valid, snake_x, snake_y, snake_dir, snake_first, snake_last);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int x, input int y, input logic [1:0] d,
                       input bit f, input bit l, input bit cd);
      seg_t s;
      s.x = x[4:0];
      s.y = y[3:0];
      s.d = d;
      s.f = f;
      s.l = l;
      s.cd = cd;
      exp_q.push_back(s);
   endtask

   task automatic push_line(input int x0, input int y0, input int n,
                            input logic [1:0] d);
      int x = x0;
      int y = y0;
      for (int i = 0; i < n; i++) begin
         push(x, y, d, i == 0, i == n - 1, i != n - 1);
         case (d)
            U: y--;
            D: y++;
            L: x--;
            default: x++;
         endcase
      end
   endtask

   task automatic do_step(input logic [1:0] d, input logic g);
      step = 1'b1;
      step_dir = d;
      grow = g;
      tick();
      step = 1'b0;
      grow = 1'b0;
      tick();
   endtask

   task automatic start_stream();
      stream_start = 1'b1;
      tick();
      stream_start = 1'b0;
   endtask

   task automatic wait_stream(input int n);
      repeat (n + 1) tick();
      chk("sb_drained", exp_q.size(), 0);
   endtask

   task automatic game_restart();
      game_rst = 1'b1;
      tick();
      game_rst = 1'b0;
      tick();
   endtask

   task automatic chk_head(input string nm, input int x, input int y);
      chk({nm, "_x"}, head_x, x);
      chk({nm, "_y"}, head_y, y);
   endtask

   int px[32];
   int py[32];
   logic [1:0] pd;

   initial begin
      tick();
      tick();
      rst = 1'b0;
      mon_en = 1'b1;
      chk_head("rst_head", 4, 7);
      chk("rst_len", length, 3);
      chk("rst_fail", failure, 0);
      chk("rst_succ", success, 0);
      chk("rst_valid", snake_valid, 0);

      // three-segment stream out of reset
      push_line(4, 7, 3, L);
      start_stream();
      wait_stream(3);

      // reversal into the neck continues straight
      do_step(L, 1'b0);
      chk_head("rev_head", 5, 7);
      chk("rev_fail", failure, 0);
      chk("rev_len", length, 3);
      push_line(5, 7, 3, L);
      start_stream();
      wait_stream(3);

      game_restart();
      do_step(R, 1'b1);
      chk("grow_len", length, 4);
      push_line(5, 7, 4, L);
      start_stream();
      wait_stream(4);

      // coil back onto the tail
      do_step(R, 1'b1);
      chk("grow_len5", length, 5);
      do_step(U, 1'b0);
      do_step(L, 1'b0);
      do_step(D, 1'b0);
      chk_head("coil_head", 5, 7);
      chk("coil_fail_pre", failure, 0);
      push(5, 7, U, 1, 0, 1);
      push(5, 6, R, 0, 0, 1);
      push(6, 6, D, 0, 0, 1);
      push(6, 7, L, 0, 0, 1);
      push(5, 7, L, 0, 1, 0);
      start_stream();
      repeat (4) tick();
      chk("coil_fail_at_seg4", failure, 0);
      tick();
      chk("coil_fail_after", failure, 1);
      wait_stream(0);
      do_step(U, 1'b0);
      chk_head("coil_frozen", 5, 7);

      // wall on the right edge
      game_restart();
      repeat (14) do_step(R, 1'b0);
      chk("wall_x18", head_x, 18);
      chk("wall_fail_pre", failure, 0);
      do_step(R, 1'b0);
      chk_head("wall_head", 19, 7);
      chk("wall_fail", failure, 1);
      do_step(R, 1'b0);
      do_step(U, 1'b0);
      chk_head("wall_frozen", 19, 7);
      chk("wall_sticky", failure, 1);

      // step held pending while streaming
      game_restart();
      push_line(4, 7, 3, L);
      start_stream();
      step = 1'b1;
      step_dir = R;
      tick();
      step = 1'b0;
      chk("pend_head_s1", head_x, 4);
      tick();
      chk("pend_head_s2", head_x, 4);
      tick();
      chk("pend_head_idle", head_x, 4);
      tick();
      chk_head("pend_applied", 5, 7);
      chk("sb_drained_pend", exp_q.size(), 0);

      // restart aborts a stream
      push(5, 7, L, 1, 0, 1);
      start_stream();
      game_rst = 1'b1;
      tick();
      game_rst = 1'b0;
      chk("abort_valid", snake_valid, 0);
      chk_head("abort_head", 4, 7);
      chk("abort_len", length, 3);
      tick();
      chk("sb_drained_abort", exp_q.size(), 0);

      // grow to full length along the board edges
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (14) do_step(R, 1'b1);
      repeat (6) do_step(D, 1'b1);
      repeat (8) do_step(L, 1'b1);
      chk_head("full_pre_head", 10, 13);
      chk("full_pre_len", length, 31);
      chk("full_pre_succ", success, 0);
      do_step(L, 1'b1);
      chk_head("full_head", 9, 13);
      chk("full_len", length, 32);
      chk("full_succ", success, 1);
      chk("full_fail", failure, 0);
      do_step(L, 1'b1);
      chk_head("full_frozen", 9, 13);
      chk("full_len_sat", length, 32);

      for (int i = 0; i < 10; i++) begin px[i] = 9 + i; py[i] = 13; end
      for (int i = 1; i <= 6; i++) begin px[9+i] = 18; py[9+i] = 13 - i; end
      for (int i = 1; i <= 14; i++) begin px[15+i] = 18 - i; py[15+i] = 7; end
      px[30] = 3; py[30] = 7;
      px[31] = 2; py[31] = 7;
      for (int i = 0; i < 32; i++) begin
         pd = L;
         if (i < 31) begin
            if (px[i+1] > px[i]) pd = R;
            else if (px[i+1] < px[i]) pd = L;
            else if (py[i+1] > py[i]) pd = D;
            else pd = U;
         end
         push(px[i], py[i], pd, i == 0, i == 31, i != 31);
      end
      start_stream();
      wait_stream(32);
      chk("full_stream_fail", failure, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/snake_body.md
SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter: MAX_LEN, 32, maximum segment count including head (2..32).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 game_rst  in  1  synchronous active-high game restart; same effect as rst.
REQ-005 step  in  1  one-cycle pulse: advance snake one tile.
REQ-006 step_dir  in  2  requested heading for step; 0=up, 1=down, 2=left, 3=right.
REQ-007 grow  in  1  sampled with step: length +1 on that step.
REQ-008 stream_start  in  1  pulse: begin head-to-tail segment stream.
REQ-009 head_x/head_y  out  5/4  current head tile.
REQ-010 snake_x/snake_y  out  5/4  streamed segment tile.
REQ-011 snake_dir  out  2  direction from this segment to the next tail-ward segment.
REQ-012 snake_first/snake_last/snake_valid  out  1 each  head flag / tail flag / segment-valid strobe.
REQ-013 length  out  6  current segment count.
REQ-014 failure/success  out  1 each  sticky game-over flags.

Function
REQ-015 Body SHALL be stored as head tile plus circular or shift buffer of MAX_LEN-1 2-bit directions; dirs[0] points head->neck.
REQ-016 Opposite(d) SHALL be d with bit0 inverted; step vectors: up y-1, down y+1, left x-1, right x+1, 5/4-bit modular arithmetic.
REQ-017 Stream SHALL begin the cycle after stream_start: snake_valid high for exactly length consecutive cycles, segment 0 = head.
REQ-018 Segment i+1 position SHALL equal segment i position plus step vector of dirs[i]; snake_dir = dirs[i].
REQ-019 snake_first SHALL be high only on segment 0, snake_last only on segment length-1; outside stream all snake_* SHALL be 0.
REQ-020 stream_start during an active stream SHALL restart from head the next cycle.
REQ-021 step during a stream, or coincident with stream_start, SHALL be held pending (with step_dir, grow) and applied on the first cycle no stream is active; one pending slot, later step overwrites.
REQ-022 Applied step: effective dir = step_dir, except step_dir == dirs[0] (reversal) uses Opposite(dirs[0]).
REQ-023 Applied step: head += vector(dir); dirs shift tail-ward; dirs[0] = Opposite(dir); length += grow, saturating at MAX_LEN.
REQ-024 New head with x==0, x==GAME_WIDTH+1, y==0 or y==GAME_HEIGHT+1 SHALL set failure in the same update; head still moves.
REQ-025 During a stream, any segment i>=1 with position equal to head SHALL set failure the following cycle.
REQ-026 grow step making length reach MAX_LEN SHALL set success.
REQ-027 While failure or success is set, steps SHALL be ignored; streaming continues.
REQ-028 failure and success SHALL remain set until rst or game_rst.
REQ-029 head_x/head_y/length SHALL update one cycle after the step is applied.

Reset
REQ-030 On rst or game_rst: head=(4,7), length=3, dirs all left(2), no stream, no pending step, failure=success=0, all snake_* = 0.
REQ-031 Reset asserted mid-stream SHALL abort it; snake_valid low the next cycle.

Structure
REQ-032 GAME_WIDTH (18), GAME_HEIGHT (13), direction encoding and Opposite SHALL live in the shared common package.
REQ-033 One sub-module natural: snake_walker (stream counter + position accumulator); rest inline.

Verification
REQ-034 Reset, stream_start -> 3 valid cycles: (4,7) first dir 2, (3,7) dir 2, (2,7) last; then valid=0.
REQ-035 step dir=3 grow=1, stream -> length 4, segments (5,7),(4,7),(3,7),(2,7).
REQ-036 step dir=2 from reset (reversal) -> treated as right; head (5,7), failure 0.
REQ-037 Steps right to x=19 -> failure=1 on that update; further steps leave head (19,7).
REQ-038 Grow to length 5, steps up,left,down -> next stream flags failure one cycle after head-matching segment.
REQ-039 step during stream -> pending; head unchanged until stream ends, then updates; game_rst mid-stream -> valid drops next cycle, reset state.
